// File: rtl/vending_controller.sv
// Vending-machine control FSM: accumulates coin credit, vends at a fixed price,
// and pays change back as a train of 100-unit pulses. All outputs are registered.
module vending_controller #(
  parameter int PRICE           = 700,
  parameter int MAX_CREDIT      = 2000,
  parameter int DISPENSE_CYCLES = 4,
  parameter int CHANGE_GAP      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        coin_100,
  input  logic        coin_500,
  input  logic        sel,
  input  logic        cancel,
  output logic [11:0] credit,
  output logic        dispense,
  output logic        change_out,
  output logic        coin_reject,
  output logic        deny,
  output logic        busy
);

  typedef enum logic [1:0] {ACCEPT, VEND, REFUND} state_t;

  // One down-counter serves both the dispense length and the change-pulse gap.
  localparam int CNT_MAX = (DISPENSE_CYCLES > CHANGE_GAP) ? DISPENSE_CYCLES : CHANGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(CHANGE_GAP - 1);
  localparam logic [12:0]      PRICE_W   = 13'(PRICE);
  localparam logic [12:0]      MAX_W     = 13'(MAX_CREDIT);
  localparam logic [12:0]      STEP_W    = 13'd100;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [12:0]      credit_w, credit_nxt, coin_sum, coin_total;
  logic             coin_any;
  logic             dispense_d, change_d, reject_d, deny_d;

  // Thirteen bits so credit + 500 can never wrap before the ceiling compare.
  assign credit_w   = {1'b0, credit};
  assign coin_any   = coin_100 | coin_500;
  assign coin_sum   = (coin_100 ? 13'd100 : 13'd0) + (coin_500 ? 13'd500 : 13'd0);
  assign coin_total = credit_w + coin_sum;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d    = state;
    cnt_d      = cnt;
    credit_nxt = credit_w;
    dispense_d = 1'b0;
    change_d   = 1'b0;
    reject_d   = 1'b0;
    deny_d     = 1'b0;

    unique case (state)
      ACCEPT: begin
        if (cancel) begin
          reject_d = coin_any;
          if (credit_w != 13'd0) begin
            state_d    = REFUND;
            change_d   = 1'b1;
            credit_nxt = credit_w - STEP_W;
            cnt_d      = GAP_LOAD;
          end
        end else if (sel) begin
          reject_d = coin_any;
          if (credit_w >= PRICE_W) begin
            state_d    = VEND;
            credit_nxt = credit_w - PRICE_W;
            dispense_d = 1'b1;
            cnt_d      = DISP_LOAD;
          end else begin
            deny_d = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_total <= MAX_W) credit_nxt = coin_total;
          else                     reject_d   = 1'b1;
        end
      end

      VEND: begin
        reject_d = coin_any;
        if (cnt == '0) begin
          // Leaving VEND with leftover credit pays the first change pulse at once.
          if (credit_w != 13'd0) begin
            state_d    = REFUND;
            change_d   = 1'b1;
            credit_nxt = credit_w - STEP_W;
            cnt_d      = GAP_LOAD;
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          cnt_d      = cnt - 1'b1;
          dispense_d = 1'b1;
        end
      end

      REFUND: begin
        reject_d = coin_any;
        if (credit_w == 13'd0) begin
          state_d = ACCEPT;
        end else if (cnt == '0) begin
          change_d   = 1'b1;
          credit_nxt = credit_w - STEP_W;
          cnt_d      = GAP_LOAD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      default: state_d = ACCEPT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCEPT;
      cnt         <= '0;
      credit      <= '0;
      dispense    <= 1'b0;
      change_out  <= 1'b0;
      coin_reject <= 1'b0;
      deny        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      credit      <= credit_nxt[11:0];
      dispense    <= dispense_d;
      change_out  <= change_d;
      coin_reject <= reject_d;
      deny        <= deny_d;
      busy        <= (state_d != ACCEPT);
    end
  end

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: coin accumulation, vend, deny, ceiling,
// cancel refund, and asynchronous reset in the middle of a refund.
module tb_vending_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coin_100, coin_500, sel, cancel;
  logic [11:0] credit;
  logic        dispense, change_out, coin_reject, deny, busy;

  int vectors = 0;
  int errors  = 0;

  vending_controller #(
    .PRICE(700), .MAX_CREDIT(2000), .DISPENSE_CYCLES(4), .CHANGE_GAP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_100(coin_100), .coin_500(coin_500), .sel(sel), .cancel(cancel),
    .credit(credit), .dispense(dispense), .change_out(change_out),
    .coin_reject(coin_reject), .deny(deny), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one input pattern for a single rising edge; returns on the following
  // falling edge with inputs cleared and the edge's results visible.
  task automatic step(input logic c100, input logic c500, input logic s, input logic c);
    coin_100 = c100; coin_500 = c500; sel = s; cancel = c;
    @(negedge clk);
    coin_100 = 1'b0; coin_500 = 1'b0; sel = 1'b0; cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    check("rst_credit", 13'(credit), 13'd0);
    check("rst_outs", {8'd0, dispense, change_out, coin_reject, deny, busy}, 13'd0);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_n = 1'b0; coin_100 = 1'b0; coin_500 = 1'b0; sel = 1'b0; cancel = 1'b0;
    @(negedge clk);
    do_reset();

    // Exact-price purchase: no change.
    step(0, 1, 0, 0); check("acc_500", 13'(credit), 13'd500);
    step(1, 0, 0, 0); check("acc_600", 13'(credit), 13'd600);
    step(1, 0, 0, 0); check("acc_700", 13'(credit), 13'd700);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check("vend1_disp", 13'(dispense), 13'd1);
      check("vend1_busy", 13'(busy), 13'd1);
      check("vend1_chg", 13'(change_out), 13'd0);
      check("vend1_credit", 13'(credit), 13'd0);
      idle(1);
    end
    check("vend1_disp_end", 13'(dispense), 13'd0);
    check("vend1_busy_end", 13'(busy), 13'd0);
    check("vend1_chg_end", 13'(change_out), 13'd0);

    // Overpay 1000, vend, then three change pulses 4 cycles apart.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0); check("acc_1000", 13'(credit), 13'd1000);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check("vend2_disp", 13'(dispense), 13'd1);
      check("vend2_credit", 13'(credit), 13'd300);
      idle(1);
    end
    for (int j = 0; j < 13; j++) begin
      check("ref2_chg", 13'(change_out), (j % 4 == 0 && j <= 8) ? 13'd1 : 13'd0);
      check("ref2_credit", 13'(credit), (j >= 8) ? 13'd0 : 13'(200 - 100 * (j / 4)));
      check("ref2_busy", 13'(busy), (j <= 8) ? 13'd1 : 13'd0);
      check("ref2_disp", 13'(dispense), 13'd0);
      idle(1);
    end

    // Insufficient credit: deny for one cycle.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); check("acc_600b", 13'(credit), 13'd600);
    step(0, 0, 1, 0);
    check("deny_pulse", 13'(deny), 13'd1);
    check("deny_credit", 13'(credit), 13'd600);
    check("deny_disp", 13'(dispense), 13'd0);
    check("deny_busy", 13'(busy), 13'd0);
    idle(1);
    check("deny_drop", 13'(deny), 13'd0);

    // Credit ceiling.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); check("acc_1800", 13'(credit), 13'd1800);
    step(0, 1, 0, 0);
    check("ceil_rej500", 13'(coin_reject), 13'd1);
    check("ceil_credit", 13'(credit), 13'd1800);
    step(1, 0, 0, 0);
    check("ceil_acc100", 13'(coin_reject), 13'd0);
    check("ceil_1900", 13'(credit), 13'd1900);
    step(1, 1, 0, 0);
    check("ceil_rej_both", 13'(coin_reject), 13'd1);
    check("ceil_both_credit", 13'(credit), 13'd1900);
    step(1, 0, 0, 0);
    check("ceil_exact_max", 13'(credit), 13'd2000);
    check("ceil_exact_rej", 13'(coin_reject), 13'd0);
    step(1, 0, 0, 0);
    check("ceil_over_rej", 13'(coin_reject), 13'd1);
    check("ceil_over_credit", 13'(credit), 13'd2000);

    do_reset();

    // Cancel with a simultaneous coin, then inputs ignored during REFUND.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); check("acc_300", 13'(credit), 13'd300);
    step(1, 0, 0, 1);
    check("cxl_rej", 13'(coin_reject), 13'd1);
    check("cxl_chg1", 13'(change_out), 13'd1);
    check("cxl_credit1", 13'(credit), 13'd200);
    check("cxl_busy", 13'(busy), 13'd1);
    idle(1);
    step(0, 1, 0, 0);
    check("ref_coin_rej", 13'(coin_reject), 13'd1);
    check("ref_coin_credit", 13'(credit), 13'd200);
    check("ref_coin_chg", 13'(change_out), 13'd0);
    step(0, 0, 1, 0);
    check("ref_sel_disp", 13'(dispense), 13'd0);
    check("ref_sel_deny", 13'(deny), 13'd0);
    check("ref_sel_credit", 13'(credit), 13'd200);
    idle(1);
    check("cxl_chg2", 13'(change_out), 13'd1);
    check("cxl_credit2", 13'(credit), 13'd100);
    idle(4);
    check("cxl_chg3", 13'(change_out), 13'd1);
    check("cxl_credit3", 13'(credit), 13'd0);
    check("cxl_busy3", 13'(busy), 13'd1);
    idle(1);
    check("cxl_done_busy", 13'(busy), 13'd0);
    check("cxl_done_chg", 13'(change_out), 13'd0);

    // Asynchronous reset between the first and second change pulse.
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    check("rr_chg1", 13'(change_out), 13'd1);
    check("rr_credit1", 13'(credit), 13'd400);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("rr_async_credit", 13'(credit), 13'd0);
    check("rr_async_chg", 13'(change_out), 13'd0);
    check("rr_async_busy", 13'(busy), 13'd0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("rr_after_chg", 13'(change_out), 13'd0);
      check("rr_after_credit", 13'(credit), 13'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
